registers: RTL and testbench
============================

// Module: registers
// PURPOSE
//  - General-purpose register file for the processor datapath: 8 entries x 8 bits.
//  - One shared address port: synchronous write, registered read.
//  - Sits between the control unit (drives addr/rd/wr) and the ALU/bus (data_in/data_out).
// PARAMETERS
//  - DATA_W  8  width of each register and of data_in/data_out
//  - ADDR_W  3  address width; DEPTH = 2**ADDR_W = 8 entries
// PORTS
//  - clk       in   1       single clock; all state updates on rising edge
//  - rst_n     in   1       reset, asynchronous, active-low
//  - addr      in   ADDR_W  register index for both read and write
//  - rd        in   1       read enable
//  - wr        in   1       write enable
//  - data_in   in   DATA_W  write data
//  - data_out  out  DATA_W  registered read data
// BEHAVIOUR
//  - Reset: rst_n low clears all 8 registers and data_out to 0 immediately, independent of clk.
//    All registers stay cleared while rst_n is low.
//  - Write: on rising clk with wr=1, mem[addr] <= data_in.
//    With wr=0, no register changes.
//  - Read: on rising clk with rd=1, data_out <= mem[addr]; latency 1 cycle.
//    With rd=0, data_out holds its last value.
//  - rd=1 and wr=1 in the same cycle: the write happens.
//    Without the bypass feature, data_out gets the pre-write contents of mem[addr] (old value).
//  - Full address range 0..7 is valid; addr 7 is an ordinary register, with no wrap or aliasing.
//    A 2-bit value applied to addr is zero-extended.
//  - X/Z on rd or wr is treated as 0: no write, data_out holds.
//  - Reset asserted mid-operation aborts any pending write; the cycle's write is lost.
//  - No handshake and no busy/ready: every cycle accepts a new command.
// CONFIGURATION
//  - REGISTERS_BYPASS_EN defined: write-to-read bypass.
//    When rd=1, wr=1 and the addresses match (single port, so always), data_out <= data_in (new value).
//  - REGISTERS_BYPASS_EN undefined: data_out <= old mem[addr] in that case.
//  - No other behaviour differs between the two builds.
// STRUCTURE
//  - registers_pkg holds DATA_W and ADDR_W defaults, DEPTH, and a reg_word_t typedef (logic [DATA_W-1:0]).
//  - Single module, no sub-modules.
//  - Storage is a reg_word_t array [DEPTH]; read mux and output register are inline.
// TESTING
//  - Reset: hold rst_n=0 mid-cycle -> data_out=0 asynchronously; reads of addr 0..7 after release return 0.
//  - Write/read-back: write 0x00@0, 0x02@1, 0x01@2, 0x03@3, 0x05@7 (wr=1 one cycle each),
//    then rd=1 at addr 0,1,2,3,7 -> data_out 0x00,0x02,0x01,0x03,0x05, each one cycle later.
//  - Hold: after reading 0x05@7, set rd=0 and change addr to 1 -> data_out stays 0x05.
//  - Simultaneous rd+wr: addr=1 holding 0x02, data_in=0xAA ->
//    data_out=0x02 (bypass off) or 0xAA (bypass on); the next read of addr 1 returns 0xAA.
//  - Write-disabled: wr=0, data_in=0xFF at addr 3 -> a later read of addr 3 still returns 0x03.
//  - Reset mid-run: assert rst_n low after loading data -> all registers read 0x00 afterwards.

Source files
------------

// File: rtl/registers_pkg.sv
// Shared sizing and word type for the 8x8 general-purpose register file.
package registers_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] reg_word_t;

endpackage

// File: rtl/registers.sv
// Register file: 8 x 8-bit entries, one shared address, synchronous write, registered read.
// Build option: define REGISTERS_BYPASS_EN to forward data_in to data_out on same-cycle rd+wr.
module registers
  import registers_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  reg_word_t mem [DEPTH];

  // Storage and output register; an X/Z enable falls through to the hold branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      data_out <= '0;
    end else begin
      if (wr) begin
        mem[addr] <= data_in;
      end
      if (rd) begin
`ifdef REGISTERS_BYPASS_EN
        data_out <= wr ? data_in : mem[addr];
`else
        data_out <= mem[addr];
`endif
      end
    end
  end

endmodule

// File: tb/tb_registers.sv
// Directed self-checking bench for the registers block (both bypass builds).
module tb_registers;

  logic       clk;
  logic       rst_n;
  logic [2:0] addr;
  logic       rd;
  logic       wr;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int n_cmp;
  int n_err;

  logic [7:0] exp_rw;
  logic [1:0] short_addr;

  registers dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .rd       (rd),
    .wr       (wr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
    addr = a; data_in = d; wr = 1'b1; rd = 1'b0;
    tick();
    wr = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [7:0] exp);
    addr = a; rd = 1'b1; wr = 1'b0;
    tick();
    rd = 1'b0;
    check(tag, data_out, exp);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b1; addr = '0; rd = 1'b0; wr = 1'b0; data_in = '0;

    // Asynchronous reset asserted mid-cycle
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_async", data_out, 8'h00);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int a = 0; a < 8; a++) begin
      read_check("reset_read", 3'(a), 8'h00);
    end

    // Load and read back
    write_reg(3'd0, 8'h00);
    write_reg(3'd1, 8'h02);
    write_reg(3'd2, 8'h01);
    write_reg(3'd3, 8'h03);
    write_reg(3'd7, 8'h05);
    read_check("rb_addr0", 3'd0, 8'h00);
    read_check("rb_addr1", 3'd1, 8'h02);
    read_check("rb_addr2", 3'd2, 8'h01);
    read_check("rb_addr3", 3'd3, 8'h03);
    read_check("rb_addr7", 3'd7, 8'h05);

    // Hold with rd low while addr moves
    addr = 3'd1; rd = 1'b0;
    tick();
    check("hold_rd0", data_out, 8'h05);

    // Simultaneous read and write
`ifdef REGISTERS_BYPASS_EN
    exp_rw = 8'hAA;
`else
    exp_rw = 8'h02;
`endif
    addr = 3'd1; data_in = 8'hAA; rd = 1'b1; wr = 1'b1;
    tick();
    rd = 1'b0; wr = 1'b0;
    check("rd_wr_same", data_out, exp_rw);
    read_check("rd_after_rdwr", 3'd1, 8'hAA);

    // Write disabled leaves contents alone
    addr = 3'd3; data_in = 8'hFF; wr = 1'b0; rd = 1'b0;
    tick();
    check("wr0_hold_out", data_out, 8'hAA);
    read_check("wr0_addr3", 3'd3, 8'h03);

    // Unknown enables behave as deasserted
    addr = 3'd2; data_in = 8'h55; wr = 1'bx; rd = 1'bx;
    tick();
    wr = 1'b0; rd = 1'b0;
    check("x_en_hold", data_out, 8'h03);
    read_check("x_en_nowrite", 3'd2, 8'h01);

    // Narrow address value is zero-extended
    short_addr = 2'd3;
    read_check("addr_zext", 3'(short_addr), 8'h03);

    // Reset mid-run aborts a pending write and clears everything
    addr = 3'd5; data_in = 8'h77; wr = 1'b1; rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_midrun", data_out, 8'h00);
    tick();
    wr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < 8; a++) begin
      read_check("post_reset_read", 3'(a), 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
